// File: rtl/cadr_trace_monitor_pkg.sv
// Shared types and constants for the CADR fetch trace monitor.
// Holds the monitor state encoding and the trace entry width helper.
// No logic; imported by the interface, the RAM wrapper's parent and the top.
package cadr_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        POSTRUN = 2'd2,
        FROZEN  = 2'd3
    } trace_state_t;

    // CPU state encoding that marks a fetch cycle on the CADR core.
    localparam logic [5:0] FETCH_STATE = 6'b000001;

    // One trace entry is {lpc, ir}.
    function automatic int entry_w(input int pc_w, input int ir_w);
        return pc_w + ir_w;
    endfunction

endpackage

// File: rtl/cadr_trace_monitor_if.sv
// CPU sample bus plus debug read port of the trace monitor.
// Master side is the CPU/host, slave side is the monitor.
// rd_data is valid one cycle after rd_addr is presented.
interface cadr_trace_monitor_if #(
    parameter int PC_W = 14,
    parameter int IR_W = 49,
    parameter int AW   = 8
);
    import cadr_trace_pkg::*;

    logic                             fetch;
    logic [PC_W-1:0]                  lpc;
    logic [IR_W-1:0]                  ir;
    logic [AW-1:0]                    rd_addr;
    logic [entry_w(PC_W, IR_W)-1:0]   rd_data;

    modport master (output fetch, lpc, ir, rd_addr, input rd_data);
    modport slave  (input fetch, lpc, ir, rd_addr, output rd_data);

endinterface

// File: rtl/cadr_trace_ram.sv
// Simple dual-port trace store: one write port, one registered read port.
// Read latency 1 cycle; a same-address write returns the old contents.
// No backpressure; writes are accepted whenever we is high.
module cadr_trace_ram #(
    parameter int AW = 8,
    parameter int DW = 63
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register clears on reset so the host never sees stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cadr_trace_monitor.sv
// Logs {lpc, ir} on every CPU fetch into a ring buffer and counts PC watch hits.
// Latency: state/counters update on the fetch edge; trace read data 1 cycle after rd_addr.
// No backpressure: the CPU is never stalled; after a fault the trace freezes instead.
module cadr_trace_monitor
    import cadr_trace_pkg::*;
#(
    parameter int PC_W   = 14,
    parameter int IR_W   = 49,
    parameter int DEPTH  = 256,
    parameter int NWATCH = 4,
    parameter int CNT_W  = 16,
    parameter int CYC_W  = 32,
    parameter int POST   = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int EW    = entry_w(PC_W, IR_W)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cadr_trace_monitor_if.slave      bus,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NWATCH*PC_W-1:0]   watch_pc,
    input  logic [NWATCH-1:0]        watch_en,
    input  logic [NWATCH*CNT_W-1:0]  watch_limit,
    output logic [AW-1:0]            wr_ptr,
    output logic                     wrapped,
    output logic [CYC_W-1:0]         cycles,
    output logic [NWATCH*CNT_W-1:0]  hits,
    output logic                     fault,
    output logic [2:0]               fault_chan,
    output logic                     frozen
);

    trace_state_t      state;
    logic [AW-1:0]     post_cnt;
    logic              log_en;
    logic [NWATCH-1:0] trip;
    logic [2:0]        trip_idx;

    // A fetch is logged only while armed; clear drops a coincident fetch.
    assign log_en = (state == RUN || state == POSTRUN) && enable && !clear && bus.fetch;

    cadr_trace_ram #(.AW(AW), .DW(EW)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (log_en),
        .waddr   (wr_ptr),
        .wdata   ({bus.lpc, bus.ir}),
        .raddr   (bus.rd_addr),
        .rdata   (bus.rd_data)
    );

    for (genvar i = 0; i < NWATCH; i++) begin : g_watch
        logic             hit;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;

        assign hit      = watch_en[i] && (bus.lpc == watch_pc[i*PC_W +: PC_W]);
        assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
        // Compare the post-increment count so limit N faults on hit N+1.
        assign trip[i]  = log_en && hit && (cnt_next > watch_limit[i*CNT_W +: CNT_W]);
        assign hits[i*CNT_W +: CNT_W] = cnt;

        // Saturating per-channel hit counter.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (clear) begin
                cnt <= '0;
            end else if (log_en && hit) begin
                cnt <= cnt_next;
            end
        end
    end

    // Lowest tripping channel wins.
    always_comb begin
        trip_idx = '0;
        for (int i = NWATCH - 1; i >= 0; i--) begin
            if (trip[i]) begin
                trip_idx = 3'(i);
            end
        end
    end

    // Monitor FSM with write pointer, fetch counter and fault/freeze flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            cycles     <= '0;
            fault      <= 1'b0;
            fault_chan <= '0;
            frozen     <= 1'b0;
            post_cnt   <= '0;
        end else if (clear) begin
            state      <= enable ? RUN : IDLE;
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            cycles     <= '0;
            fault      <= 1'b0;
            fault_chan <= '0;
            frozen     <= 1'b0;
            post_cnt   <= '0;
        end else begin
            if (log_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == AW'(DEPTH - 1)) begin
                    wrapped <= 1'b1;
                end
                if (cycles != '1) begin
                    cycles <= cycles + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    // Re-arming after a pause resumes the post-fault countdown.
                    if (enable) begin
                        state <= fault ? POSTRUN : RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (|trip) begin
                        fault      <= 1'b1;
                        fault_chan <= trip_idx;
                        if (POST == 0) begin
                            state  <= FROZEN;
                            frozen <= 1'b1;
                        end else begin
                            state    <= POSTRUN;
                            post_cnt <= AW'(POST);
                        end
                    end
                end
                POSTRUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (log_en) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            state  <= FROZEN;
                            frozen <= 1'b1;
                        end
                    end
                end
                FROZEN: begin
                    state <= FROZEN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
